// File: rtl/psum_requant_row_pkg.sv
// Shared conv-array definitions: default widths and drain-state encoding,
// so the MAC row and its drain stage agree on vector packing.
package psum_requant_row_pkg;

  localparam int DW_DEF     = 8;
  localparam int OW_DEF     = 19;
  localparam int COLUMN_DEF = 6;
  localparam int SW_DEF     = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/psum_requant_row_requant_unit.sv
// Single-column requantiser: bias add, round-half-up, arithmetic shift,
// optional ReLU and signed saturation to DW bits. Purely combinational.
module requant_unit #(
  parameter int DW = 8,
  parameter int OW = 19,
  parameter int SW = 5
) (
  input  logic [OW-1:0] psum,
  input  logic [OW-1:0] bias,
  input  logic [SW-1:0] shift,
  input  logic          relu_en,
  output logic [DW-1:0] data
);

  localparam logic        [OW+1:0] ONE     = (OW+2)'(1);
  localparam logic signed [OW+1:0] SAT_MAX = (OW+2)'((1 << (DW-1)) - 1);
  localparam logic signed [OW+1:0] SAT_MIN = ~SAT_MAX;

  logic        [SW-1:0] s;
  logic signed [OW:0]   sum;
  logic        [OW+1:0] rnd;
  logic signed [OW+1:0] r;
  logic signed [OW+1:0] q;

  always_comb begin
    // Shifts beyond OW would only replicate the sign bit, so clamp there.
    s   = (shift > SW'(OW)) ? SW'(OW) : shift;
    sum = {psum[OW-1], psum} + {bias[OW-1], bias};
    rnd = '0;
    if (s != '0) rnd = ONE << (s - SW'(1));
    r = {sum[OW], sum} + rnd;
    q = r >>> s;
    if (relu_en && q[OW+1]) q = '0;
    if (q > SAT_MAX)      data = SAT_MAX[DW-1:0];
    else if (q < SAT_MIN) data = SAT_MIN[DW-1:0];
    else                  data = q[DW-1:0];
  end

endmodule

// File: rtl/psum_requant_row.sv
// Row drain stage: captures one row of partial sums, then streams the
// requantised columns out one per cycle on a valid/ready interface.
//
// state | meaning
// IDLE  | no row held, in_ready high
// DRAIN | streaming held row, column col presented on out_data
module psum_requant_row
  import psum_requant_row_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int OW     = OW_DEF,
  parameter int COLUMN = COLUMN_DEF,
  parameter int SW     = SW_DEF,
  parameter int CW     = $clog2(COLUMN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COLUMN*OW-1:0] psum_in,
  input  logic [COLUMN*OW-1:0] bias_in,
  input  logic [SW-1:0]        shift,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_col,
  output logic                 out_last
);

  localparam logic [CW-1:0] LAST_COL = CW'(COLUMN - 1);

  state_t               state;
  logic [CW-1:0]        col;
  logic [COLUMN*OW-1:0] psum_q;
  logic [COLUMN*OW-1:0] bias_q;
  logic [SW-1:0]        shift_q;
  logic                 relu_q;
  logic [OW-1:0]        psum_sel;
  logic [OW-1:0]        bias_sel;
  logic                 accept;

  assign out_valid = (state == DRAIN);
  assign out_col   = col;
  assign out_last  = (state == DRAIN) && (col == LAST_COL);
  // Ready also on the final column handshake so rows chain with no bubble.
  assign in_ready  = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      psum_q  <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      if (accept) begin
        psum_q  <= psum_in;
        bias_q  <= bias_in;
        shift_q <= shift;
        relu_q  <= relu_en;
        col     <= '0;
        state   <= DRAIN;
      end else if ((state == DRAIN) && out_ready) begin
        if (col == LAST_COL) begin
          state <= IDLE;
          col   <= '0;
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  always_comb begin
    psum_sel = '0;
    bias_sel = '0;
    for (int i = 0; i < COLUMN; i++) begin
      if (col == CW'(i)) begin
        psum_sel = psum_q[i*OW +: OW];
        bias_sel = bias_q[i*OW +: OW];
      end
    end
  end

  requant_unit #(
    .DW(DW),
    .OW(OW),
    .SW(SW)
  ) u_requant (
    .psum   (psum_sel),
    .bias   (bias_sel),
    .shift  (shift_q),
    .relu_en(relu_q),
    .data   (out_data)
  );

endmodule

// File: tb/tb_psum_requant_row.sv
// Bench for psum_requant_row: directed corner cases plus randomized rows with
// random backpressure, checked against an integer-arithmetic reference model.
module tb_psum_requant_row;

  localparam int DW     = 8;
  localparam int OW     = 19;
  localparam int COLUMN = 6;
  localparam int SW     = 5;
  localparam int CW     = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [COLUMN*OW-1:0] psum_in;
  logic [COLUMN*OW-1:0] bias_in;
  logic [SW-1:0]        shift;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_col;
  logic                 out_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int data;
    int col;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   seen[COLUMN];
  int   vp[COLUMN];
  int   vb[COLUMN];

  psum_requant_row dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .psum_in  (psum_in),
    .bias_in  (bias_in),
    .shift    (shift),
    .relu_en  (relu_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_col  (out_col),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the row values.
  function automatic int ref_q(input logic [OW-1:0] p, input logic [OW-1:0] b,
                               input int sh, input bit relu);
    longint sum, r, q;
    int s;
    sum = longint'($signed(p)) + longint'($signed(b));
    s   = (sh > OW) ? OW : sh;
    r   = sum + ((s > 0) ? (longint'(1) <<< (s - 1)) : longint'(0));
    q   = r >>> s;
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_col", int'(out_col), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_data", int'($signed(out_data)), e.data);
          chk("mon_col", int'(out_col), e.col);
          chk("mon_last", int'(out_last), e.last);
        end
        if (out_col < CW'(COLUMN)) seen[out_col] = int'($signed(out_data));
      end
      if (in_valid && in_ready) begin
        for (int c = 0; c < COLUMN; c++) begin
          exp_t n;
          n.data = ref_q(psum_in[c*OW +: OW], bias_in[c*OW +: OW], int'(shift), relu_en);
          n.col  = c;
          n.last = (c == COLUMN - 1) ? 1 : 0;
          exp_q.push_back(n);
        end
      end
    end
  end

  task automatic clear_vec();
    for (int c = 0; c < COLUMN; c++) begin
      vp[c]   = 0;
      vb[c]   = 0;
      seen[c] = 999;
    end
  endtask

  task automatic load_inputs(input int sh, input int rl);
    for (int c = 0; c < COLUMN; c++) begin
      psum_in[c*OW +: OW] = OW'(vp[c]);
      bias_in[c*OW +: OW] = OW'(vb[c]);
    end
    shift   = SW'(sh);
    relu_en = rl[0];
  endtask

  task automatic send_vec(input int sh, input int rl);
    int got;
    @(posedge clk); #1;
    load_inputs(sh, rl);
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (got == 0) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int done;
    done = 0;
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) done = 1;
    end
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < COLUMN; c++) begin
      psum_in[c*OW +: OW] = OW'($urandom);
      if ($urandom_range(0, 1) == 1) bias_in[c*OW +: OW] = OW'($urandom);
      else bias_in[c*OW +: OW] = OW'(int'($urandom_range(0, 200)) - 100);
    end
    if ($urandom_range(0, 3) == 0) shift = SW'($urandom_range(0, 31));
    else shift = SW'($urandom_range(0, 12));
    relu_en = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed %0d expected 0", checks);
    $fatal(1);
  end

  initial begin
    int exp2, found, stale, sent, acc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    psum_in = '0;
    bias_in = '0;
    shift = '0;
    relu_en = 1'b0;
    clear_vec();

    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_col", int'(out_col), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(in_ready), 1);

    // Plain requantisation, plus first-column latency
    out_ready = 1'b1;
    clear_vec();
    vp[0] = 1000; vp[1] = -1000;
    send_vec(3, 0);
    @(negedge clk);
    chk("lat_valid", int'(out_valid), 1);
    wait_drain();
    chk("t1_col0", seen[0], 125);
    chk("t1_col1", seen[1], -125);

    // Saturation both ways, then ReLU on the negative extreme
    clear_vec();
    vp[0] = 262143; vp[1] = -262144;
    send_vec(0, 0);
    wait_drain();
    chk("sat_pos", seen[0], 127);
    chk("sat_neg", seen[1], -128);
    clear_vec();
    vp[1] = -262144;
    send_vec(0, 1);
    wait_drain();
    chk("sat_relu", seen[1], 0);

    // Shift clamp and bias
    clear_vec();
    vp[0] = 100; vb[0] = -50;
    send_vec(31, 0);
    wait_drain();
    chk("clamp_s31", seen[0], 0);
    clear_vec();
    vp[0] = 100; vb[0] = -50;
    send_vec(1, 0);
    wait_drain();
    chk("shift1", seen[0], 25);

    // Backpressure while column 2 is presented
    clear_vec();
    for (int c = 0; c < COLUMN; c++) begin
      vp[c] = int'($urandom_range(0, 4000)) - 2000;
      vb[c] = int'($urandom_range(0, 400)) - 200;
    end
    out_ready = 1'b0;
    send_vec(2, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp2 = ref_q(OW'(vp[2]), OW'(vb[2]), 2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_col", int'(out_col), 2);
      chk("bp_data", int'($signed(out_data)), exp2);
      chk("bp_last", int'(out_last), 0);
      chk("bp_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back vectors with in_valid held
    @(posedge clk); #1;
    for (int c = 0; c < COLUMN; c++) begin vp[c] = 7000 * c - 15000; vb[c] = 3 * c; end
    load_inputs(6, 0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", int'(in_ready), 1);
    @(posedge clk); #1;
    for (int c = 0; c < COLUMN; c++) begin vp[c] = 20000 - 9000 * c; vb[c] = -c; end
    load_inputs(7, 1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk("b2b_valid", int'(out_valid), (k <= 12) ? 1 : 0);
      chk("b2b_last", int'(out_last), (k == 6 || k == 12) ? 1 : 0);
      if (k <= 12) chk("b2b_col", int'(out_col), (k - 1) % COLUMN);
      if (k == 6) chk("b2b_ready6", int'(in_ready), 1);
      @(posedge clk); #1;
      if (k == 6) in_valid = 1'b0;
    end
    chk("b2b_queue", exp_q.size(), 0);

    // Reset in the middle of a drain
    clear_vec();
    for (int c = 0; c < COLUMN; c++) vp[c] = 500 * c + 100;
    send_vec(2, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (out_valid && out_col == CW'(3)) found = 1;
    end
    chk("rst_mid_found", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ready", int'(in_ready), 0);
    chk("rst_mid_last", int'(out_last), 0);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", int'(in_ready), 1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_stale", stale, 0);

    // Randomized rows with random backpressure and idle-time input noise
    sent = 0;
    acc = 0;
    for (int cyc = 0; cyc < 4000 && (sent < 40 || exp_q.size() > 0 || out_valid); cyc++) begin
      @(posedge clk); #1;
      if (in_valid && acc == 1) begin
        in_valid = 1'b0;
        sent++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid) begin
        rand_inputs();
        if (sent < 40 && $urandom_range(0, 2) != 0) in_valid = 1'b1;
      end
      @(negedge clk);
      acc = (in_valid && in_ready) ? 1 : 0;
    end
    chk("rand_sent", sent, 40);
    chk("rand_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
